// File: rtl/mem_fill_pkg.sv
// Shared types and constants for the memory-side line-fill controller.
package mem_fill_pkg;

    typedef enum logic [1:0] {IDLE, WRITE, FILL, DONE} state_t;
    typedef enum logic {PORT_PROG, PORT_DATA} port_t;

    localparam int LINE_BYTES  = 64;
    localparam int BEAT_IDX_W  = 4;
    localparam int LINE_ADDR_W = 18;

    // Byte address of one beat inside a 64-byte line, zero-extended to the bus width.
    function automatic logic [31:0] beat_addr(input logic [LINE_ADDR_W-1:0] line_addr,
                                              input logic [BEAT_IDX_W-1:0]  beat);
        return 32'({line_addr, beat, 2'b00});
    endfunction

endpackage

// File: rtl/wb_buffer.sv
// Write-back capture FIFO; wrap-bit pointers distinguish full from empty.
module wb_buffer
    import mem_fill_pkg::*;
#(
    parameter int WIDTH = 64,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign do_pop  = pop && !empty;
    // A simultaneous pop frees the slot, so a push into a full buffer is still taken.
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr[AW-1:0]];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mem_fill_ctrl.sv
// Memory-side stage: drains write-backs and fills 512-bit prog/data lines
// over a 32-bit pipelined bus.
//
//  state | meaning
//  IDLE  | pick work: pending write-back first, then a line fill
//  WRITE | present buffer head as one bus write, pop on acceptance
//  FILL  | issue 16 read beats, assemble returned beats into line_buf
//  DONE  | publish line to the selected port, mark it served
module mem_fill_ctrl
    import mem_fill_pkg::*;
#(
    parameter int LINE_BEATS      = 16,
    parameter int WB_DEPTH        = 4,
    parameter int MAX_OUTSTANDING = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         is_req_f_prog,
    input  logic [17:0]  req_addr_f_prog,
    input  logic         is_req_f_data,
    input  logic [17:0]  req_addr_f_data,
    input  logic         fifo_empty,
    input  logic [31:0]  write_back_data,
    input  logic [31:0]  write_back_addr,
    output logic [511:0] read_prog_data,
    output logic [7:0]   read_prog_addr,
    output logic [511:0] read_data_data,
    output logic [7:0]   read_data_addr,
    output logic         mem_valid,
    input  logic         mem_ready,
    output logic         mem_we,
    output logic [31:0]  mem_addr,
    output logic [31:0]  mem_wdata,
    input  logic         mem_rvalid,
    input  logic [31:0]  mem_rdata,
    output logic         wb_overflow
);

    localparam int CNT_W = $clog2(LINE_BEATS) + 1;
    localparam logic [CNT_W-1:0] BEATS_C = CNT_W'(LINE_BEATS);
    localparam logic [CNT_W-1:0] LAST_C  = CNT_W'(LINE_BEATS - 1);
    localparam logic [CNT_W-1:0] MAX_C   = CNT_W'(MAX_OUTSTANDING);

    state_t           state, state_nxt;
    port_t            fill_port;
    logic [17:0]      fill_addr;
    logic [CNT_W-1:0] issued, returned, outstanding;
    logic [511:0]     line_buf;
    logic             served_prog, served_data;
    logic [17:0]      served_addr_prog, served_addr_data;
    logic             rr_data_first;
    logic             pend_prog, pend_data, grant_data;
    logic             start_fill, issue;

    logic             wb_push, wb_pop, wb_full, wb_empty;
    logic [63:0]      wb_head;

    assign wb_push = !fifo_empty;

    wb_buffer #(.WIDTH(64), .DEPTH(WB_DEPTH)) u_wb_buffer (
        .clk   (clk),
        .reset (reset),
        .push  (wb_push),
        .pop   (wb_pop),
        .din   ({write_back_addr, write_back_data}),
        .dout  (wb_head),
        .full  (wb_full),
        .empty (wb_empty)
    );

    assign pend_prog   = is_req_f_prog && !(served_prog && (req_addr_f_prog == served_addr_prog));
    assign pend_data   = is_req_f_data && !(served_data && (req_addr_f_data == served_addr_data));
    assign grant_data  = (pend_prog && pend_data) ? rr_data_first : pend_data;
    assign outstanding = issued - returned;

    always_comb begin
        state_nxt  = state;
        mem_valid  = 1'b0;
        mem_we     = 1'b0;
        mem_addr   = '0;
        mem_wdata  = '0;
        wb_pop     = 1'b0;
        issue      = 1'b0;
        start_fill = 1'b0;
        case (state)
            IDLE: begin
                // A write-back arriving this cycle already outranks a fill.
                if (!wb_empty || !fifo_empty) begin
                    state_nxt = WRITE;
                end else if (pend_prog || pend_data) begin
                    state_nxt  = FILL;
                    start_fill = 1'b1;
                end
            end
            WRITE: begin
                if (!wb_empty) begin
                    mem_valid = 1'b1;
                    mem_we    = 1'b1;
                    mem_addr  = wb_head[63:32];
                    mem_wdata = wb_head[31:0];
                    if (mem_ready) begin
                        wb_pop    = 1'b1;
                        state_nxt = IDLE;
                    end
                end else begin
                    state_nxt = IDLE;
                end
            end
            FILL: begin
                if ((issued < BEATS_C) && (outstanding < MAX_C)) begin
                    mem_valid = 1'b1;
                    mem_addr  = beat_addr(fill_addr, issued[BEAT_IDX_W-1:0]);
                    issue     = mem_ready;
                end
                if (mem_rvalid && (returned == LAST_C)) state_nxt = DONE;
            end
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state         <= IDLE;
            fill_port     <= PORT_PROG;
            fill_addr     <= '0;
            issued        <= '0;
            returned      <= '0;
            line_buf      <= '0;
            rr_data_first <= 1'b1;
        end else begin
            state <= state_nxt;
            if (start_fill) begin
                fill_port <= grant_data ? PORT_DATA : PORT_PROG;
                fill_addr <= grant_data ? req_addr_f_data : req_addr_f_prog;
                issued    <= '0;
                returned  <= '0;
                if (pend_prog && pend_data) rr_data_first <= !rr_data_first;
            end
            if (issue) issued <= issued + 1'b1;
            if ((state == FILL) && mem_rvalid) begin
                line_buf[{returned[BEAT_IDX_W-1:0], 5'b0} +: 32] <= mem_rdata;
                returned <= returned + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            read_prog_data   <= '0;
            read_prog_addr   <= '0;
            read_data_data   <= '0;
            read_data_addr   <= '0;
            served_prog      <= 1'b0;
            served_data      <= 1'b0;
            served_addr_prog <= '0;
            served_addr_data <= '0;
            wb_overflow      <= 1'b0;
        end else begin
            if (wb_push && wb_full && !wb_pop) wb_overflow <= 1'b1;
            if ((state == DONE) && (fill_port == PORT_PROG)) begin
                read_prog_data <= line_buf;
                read_prog_addr <= fill_addr[7:0];
            end
            if ((state == DONE) && (fill_port == PORT_DATA)) begin
                read_data_data <= line_buf;
                read_data_addr <= fill_addr[7:0];
            end
            // A dropped request clears served even if its fill is just finishing.
            if (!is_req_f_prog) begin
                served_prog <= 1'b0;
            end else if ((state == DONE) && (fill_port == PORT_PROG)) begin
                served_prog      <= 1'b1;
                served_addr_prog <= fill_addr;
            end
            if (!is_req_f_data) begin
                served_data <= 1'b0;
            end else if ((state == DONE) && (fill_port == PORT_DATA)) begin
                served_data      <= 1'b1;
                served_addr_data <= fill_addr;
            end
        end
    end

endmodule

// File: tb/tb_mem_fill_ctrl.sv
// Scenario bench for mem_fill_ctrl: bus transactions are scored against an
// expectation queue filled as stimulus is driven.
module tb_mem_fill_ctrl;

    logic         clk;
    logic         reset;
    logic         is_req_f_prog;
    logic [17:0]  req_addr_f_prog;
    logic         is_req_f_data;
    logic [17:0]  req_addr_f_data;
    logic         fifo_empty;
    logic [31:0]  write_back_data;
    logic [31:0]  write_back_addr;
    logic [511:0] read_prog_data;
    logic [7:0]   read_prog_addr;
    logic [511:0] read_data_data;
    logic [7:0]   read_data_addr;
    logic         mem_valid;
    logic         mem_ready;
    logic         mem_we;
    logic [31:0]  mem_addr;
    logic [31:0]  mem_wdata;
    logic         mem_rvalid;
    logic [31:0]  mem_rdata;
    logic         wb_overflow;

    mem_fill_ctrl dut (
        .clk             (clk),
        .reset           (reset),
        .is_req_f_prog   (is_req_f_prog),
        .req_addr_f_prog (req_addr_f_prog),
        .is_req_f_data   (is_req_f_data),
        .req_addr_f_data (req_addr_f_data),
        .fifo_empty      (fifo_empty),
        .write_back_data (write_back_data),
        .write_back_addr (write_back_addr),
        .read_prog_data  (read_prog_data),
        .read_prog_addr  (read_prog_addr),
        .read_data_data  (read_data_data),
        .read_data_addr  (read_data_addr),
        .mem_valid       (mem_valid),
        .mem_ready       (mem_ready),
        .mem_we          (mem_we),
        .mem_addr        (mem_addr),
        .mem_wdata       (mem_wdata),
        .mem_rvalid      (mem_rvalid),
        .mem_rdata       (mem_rdata),
        .wb_overflow     (wb_overflow)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
    } txn_t;

    txn_t        exp_q[$];
    logic [31:0] rd_pipe[$];
    int          checks;
    int          errors;
    int          acc_cnt;
    int          rv_cnt;
    bit          ready_en;
    bit          pat_beat;

    function automatic logic [31:0] mem_fn(input logic [31:0] a);
        if (pat_beat) return {28'b0, a[5:2]};
        return (a ^ 32'h5A5A_0000) + 32'd7;
    endfunction

    function automatic logic [31:0] line_beat_addr(input logic [17:0] la, input int k);
        logic [3:0] kk;
        kk = 4'(k);
        return {8'b0, la, kk, 2'b00};
    endfunction

    function automatic logic [511:0] exp_line(input logic [17:0] la);
        logic [511:0] l;
        l = '0;
        for (int k = 0; k < 16; k++) l[32*k +: 32] = mem_fn(line_beat_addr(la, k));
        return l;
    endfunction

    task automatic push_fill(input logic [17:0] la);
        for (int k = 0; k < 16; k++) exp_q.push_back({1'b0, line_beat_addr(la, k), 32'h0});
    endtask

    // Bus slave: one-cycle read latency, checks each accepted request in order.
    task automatic mem_responder();
        txn_t t;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            mem_rdata  = '0;
            if (reset === 1'b1 && rd_pipe.size() > 0) begin
                mem_rvalid = 1'b1;
                mem_rdata  = rd_pipe.pop_front();
                rv_cnt++;
            end
            mem_ready = ready_en;
            if (reset === 1'b1 && mem_valid === 1'b1 && mem_ready) begin
                acc_cnt++;
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL bus_unexpected: got we=%0b addr=%08h wdata=%08h, required no transaction",
                             mem_we, mem_addr, mem_wdata);
                end else begin
                    t = exp_q.pop_front();
                    if (mem_we !== t.we || mem_addr !== t.addr || (t.we && mem_wdata !== t.data)) begin
                        errors++;
                        $display("FAIL bus_txn: got we=%0b addr=%08h wdata=%08h, required we=%0b addr=%08h wdata=%08h",
                                 mem_we, mem_addr, mem_wdata, t.we, t.addr, t.data);
                    end
                end
                if (!mem_we) rd_pipe.push_back(mem_fn(mem_addr));
            end
        end
    endtask

    task automatic wait_drain(input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_q.size() == 0) begin
                ok = 1'b1;
                break;
            end
        end
        repeat (4) @(negedge clk);
    endtask

    task automatic drop_requests();
        @(negedge clk);
        is_req_f_prog = 1'b0;
        is_req_f_data = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (mem_valid !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0) begin
            errors++;
            $display("FAIL reset_bus: got valid=%0b we=%0b addr=%08h, required all 0", mem_valid, mem_we, mem_addr);
        end
        checks++;
        if (read_prog_data !== '0 || read_data_data !== '0 || read_prog_addr !== '0 ||
            read_data_addr !== '0 || wb_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got prog_addr=%02h data_addr=%02h ovf=%0b, required all 0",
                     read_prog_addr, read_data_addr, wb_overflow);
        end
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (mem_valid !== 1'b0) begin
            errors++;
            $display("FAIL idle_after_reset: got mem_valid=%0b, required 0", mem_valid);
        end
    endtask

    task automatic test_prog_fill();
        bit ok;
        int acc0;
        pat_beat = 1'b1;
        @(negedge clk);
        is_req_f_prog   = 1'b1;
        req_addr_f_prog = 18'h00A5C;
        push_fill(18'h00A5C);
        wait_drain(200, ok);
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL prog_fill_timeout: got %0d beats left, required 0", exp_q.size());
        end
        checks++;
        if (read_prog_addr !== 8'h5C) begin
            errors++;
            $display("FAIL prog_addr: got %02h, required 5c", read_prog_addr);
        end
        checks++;
        if (read_prog_data[31:0] !== 32'd0 || read_prog_data[511:480] !== 32'd15) begin
            errors++;
            $display("FAIL prog_beats: got first=%0d last=%0d, required 0 and 15",
                     read_prog_data[31:0], read_prog_data[511:480]);
        end
        checks++;
        if (read_prog_data !== exp_line(18'h00A5C)) begin
            errors++;
            $display("FAIL prog_line: got %h, required %h", read_prog_data, exp_line(18'h00A5C));
        end
        checks++;
        if (read_data_data !== '0 || read_data_addr !== '0) begin
            errors++;
            $display("FAIL data_untouched: got addr=%02h, required data port still 0", read_data_addr);
        end
        acc0 = acc_cnt;
        repeat (30) @(negedge clk);
        checks++;
        if (acc_cnt !== acc0) begin
            errors++;
            $display("FAIL no_reissue: got %0d extra transactions, required 0", acc_cnt - acc0);
        end
        drop_requests();
        pat_beat = 1'b0;
    endtask

    task automatic test_round_robin();
        bit ok;
        @(negedge clk);
        is_req_f_prog   = 1'b1;
        req_addr_f_prog = 18'h1;
        is_req_f_data   = 1'b1;
        req_addr_f_data = 18'h2;
        push_fill(18'h2);
        push_fill(18'h1);
        wait_drain(300, ok);
        checks++;
        if (!ok || read_data_addr !== 8'h02 || read_prog_addr !== 8'h01) begin
            errors++;
            $display("FAIL rr_first_tie: got ok=%0b data_addr=%02h prog_addr=%02h, required 1 02 01",
                     ok, read_data_addr, read_prog_addr);
        end
        checks++;
        if (read_data_data !== exp_line(18'h2) || read_prog_data !== exp_line(18'h1)) begin
            errors++;
            $display("FAIL rr_first_lines: got data[31:0]=%08h prog[31:0]=%08h, required %08h %08h",
                     read_data_data[31:0], read_prog_data[31:0], mem_fn(32'h80), mem_fn(32'h40));
        end
        @(negedge clk);
        req_addr_f_prog = 18'h3;
        req_addr_f_data = 18'h4;
        push_fill(18'h3);
        push_fill(18'h4);
        wait_drain(300, ok);
        checks++;
        if (!ok || read_prog_data !== exp_line(18'h3) || read_data_data !== exp_line(18'h4) ||
            read_prog_addr !== 8'h03 || read_data_addr !== 8'h04) begin
            errors++;
            $display("FAIL rr_second_tie: got ok=%0b prog_addr=%02h data_addr=%02h, required 1 03 04",
                     ok, read_prog_addr, read_data_addr);
        end
        drop_requests();
    endtask

    task automatic test_write_order();
        bit ok;
        @(negedge clk);
        is_req_f_data   = 1'b1;
        req_addr_f_data = 18'h10;
        for (int i = 0; i < 3; i++) exp_q.push_back({1'b1, 32'h100 + 32'(4*i), 32'hC0DE_0000 + 32'(i)});
        push_fill(18'h10);
        for (int i = 0; i < 3; i++) begin
            fifo_empty      = 1'b0;
            write_back_addr = 32'h100 + 32'(4*i);
            write_back_data = 32'hC0DE_0000 + 32'(i);
            @(negedge clk);
        end
        fifo_empty = 1'b1;
        wait_drain(200, ok);
        checks++;
        if (!ok || read_data_addr !== 8'h10 || read_data_data !== exp_line(18'h10)) begin
            errors++;
            $display("FAIL write_then_fill: got ok=%0b data_addr=%02h, required 1 10 with matching line",
                     ok, read_data_addr);
        end
        drop_requests();
    endtask

    task automatic test_write_stall();
        bit ok;
        int acc0;
        ready_en = 1'b0;
        acc0 = acc_cnt;
        @(negedge clk);
        exp_q.push_back({1'b1, 32'h200, 32'hDEAD_BEEF});
        fifo_empty      = 1'b0;
        write_back_addr = 32'h200;
        write_back_data = 32'hDEAD_BEEF;
        @(negedge clk);
        fifo_empty = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (mem_valid === 1'b1) break;
            @(negedge clk);
        end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (mem_valid !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h200 || mem_wdata !== 32'hDEAD_BEEF) begin
                errors++;
                $display("FAIL stall_stable: got valid=%0b we=%0b addr=%08h wdata=%08h, required 1 1 00000200 deadbeef",
                         mem_valid, mem_we, mem_addr, mem_wdata);
            end
            @(negedge clk);
            #1;
        end
        ready_en = 1'b1;
        wait_drain(50, ok);
        repeat (5) @(negedge clk);
        checks++;
        if (!ok || acc_cnt - acc0 !== 1) begin
            errors++;
            $display("FAIL stall_one_write: got %0d writes, required 1", acc_cnt - acc0);
        end
        checks++;
        if (wb_overflow !== 1'b0) begin
            errors++;
            $display("FAIL no_overflow: got %0b, required 0", wb_overflow);
        end
    endtask

    task automatic test_overflow();
        bit ok;
        int acc0;
        ready_en = 1'b0;
        acc0 = acc_cnt;
        @(negedge clk);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) exp_q.push_back({1'b1, 32'h300 + 32'(4*i), 32'hF00D_0000 + 32'(i)});
            fifo_empty      = 1'b0;
            write_back_addr = 32'h300 + 32'(4*i);
            write_back_data = 32'hF00D_0000 + 32'(i);
            @(negedge clk);
        end
        fifo_empty = 1'b1;
        #1;
        checks++;
        if (wb_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_set: got %0b, required 1", wb_overflow);
        end
        ready_en = 1'b1;
        wait_drain(100, ok);
        repeat (10) @(negedge clk);
        checks++;
        if (!ok || acc_cnt - acc0 !== 4) begin
            errors++;
            $display("FAIL overflow_writes: got %0d writes, required 4", acc_cnt - acc0);
        end
        checks++;
        if (wb_overflow !== 1'b1) begin
            errors++;
            $display("FAIL overflow_sticky: got %0b, required 1", wb_overflow);
        end
    endtask

    task automatic test_reset_mid_fill();
        bit ok;
        int base;
        @(negedge clk);
        base = rv_cnt;
        is_req_f_data   = 1'b1;
        req_addr_f_data = 18'h31234;
        push_fill(18'h31234);
        ok = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (rv_cnt >= base + 8) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL mid_fill_timeout: got %0d beats returned, required 8", rv_cnt - base);
        end
        @(negedge clk);
        #2;
        reset         = 1'b0;
        is_req_f_data = 1'b0;
        exp_q.delete();
        #1;
        checks++;
        if (mem_valid !== 1'b0 || mem_we !== 1'b0 || mem_addr !== '0 || mem_wdata !== '0 ||
            read_prog_data !== '0 || read_prog_addr !== '0 || read_data_data !== '0 ||
            read_data_addr !== '0 || wb_overflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid_fill: got valid=%0b data_addr=%02h prog_addr=%02h ovf=%0b, required all 0",
                     mem_valid, read_data_addr, read_prog_addr, wb_overflow);
        end
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        repeat (4) @(negedge clk);
        checks++;
        if (mem_valid !== 1'b0 || read_data_data !== '0) begin
            errors++;
            $display("FAIL late_rvalid_ignored: got valid=%0b data[31:0]=%08h, required 0 0",
                     mem_valid, read_data_data[31:0]);
        end
        is_req_f_data   = 1'b1;
        req_addr_f_data = 18'h00ABC;
        push_fill(18'h00ABC);
        wait_drain(200, ok);
        checks++;
        if (!ok || read_data_addr !== 8'hBC || read_data_data !== exp_line(18'h00ABC)) begin
            errors++;
            $display("FAIL refill_after_reset: got ok=%0b addr=%02h data[31:0]=%08h, required 1 bc %08h",
                     ok, read_data_addr, read_data_data[31:0], mem_fn(32'h0002AF00));
        end
        drop_requests();
    endtask

    initial begin
        checks          = 0;
        errors          = 0;
        acc_cnt         = 0;
        rv_cnt          = 0;
        ready_en        = 1'b1;
        pat_beat        = 1'b0;
        reset           = 1'b0;
        is_req_f_prog   = 1'b0;
        req_addr_f_prog = '0;
        is_req_f_data   = 1'b0;
        req_addr_f_data = '0;
        fifo_empty      = 1'b1;
        write_back_data = '0;
        write_back_addr = '0;
        mem_ready       = 1'b1;
        mem_rvalid      = 1'b0;
        mem_rdata       = '0;
        fork
            mem_responder();
        join_none
        test_reset();
        test_prog_fill();
        test_round_robin();
        test_write_order();
        test_write_stall();
        test_overflow();
        test_reset_mid_fill();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL leftover_expected: got %0d pending, required 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
